// File: rtl/ppu_pipe_ctrl_if.sv
// ppu_pipe_ctrl_if
// Handshake bundle between the PPU front end, the pipeline controller and
// the downstream consumer of finished operations.
//
//   valid_i  front end presents an operation
//   op       opcode tag of the presented operation
//   ready_o  controller accepts valid_i/op this cycle
//   flush_i  discard every in-flight operation
//   ready_i  downstream accepts the output-stage operation
//   valid_o  output stage holds a valid operation
//   op_o     opcode tag of the output-stage operation (0 when not valid)
//
// Modports: slave = the controller, master = the surrounding environment.
interface ppu_pipe_ctrl_if #(
    parameter int OP_SIZE = 3
);
    logic               valid_i;
    logic [OP_SIZE-1:0] op;
    logic               ready_o;
    logic               flush_i;
    logic               ready_i;
    logic               valid_o;
    logic [OP_SIZE-1:0] op_o;

    modport master (
        output valid_i,
        output op,
        output flush_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  op_o
    );

    modport slave (
        input  valid_i,
        input  op,
        input  flush_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output op_o
    );
endinterface

// File: rtl/ppu_pipe_ctrl.sv
// ppu_pipe_ctrl
// Pipeline control unit for the PPU datapath. Tracks a valid bit and an
// opcode tag per stage of an N_STAGES-deep global-stall shift register and
// produces the stage enables / stage valids that gate the datapath registers.
// Downstream backpressure freezes the whole pipe; flush drops everything.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus            handshake bundle (slave side), see ppu_pipe_ctrl_if
//   stage_en_o     per-stage register enable for the datapath
//   stage_valid_o  per-stage valid bits, bit 0 is the input stage
//   stall_o        pipeline frozen by backpressure
//   in_flight_o    number of valid stages
//   idle_o         no operation in flight
module ppu_pipe_ctrl #(
    parameter  int N_STAGES = 3,
    parameter  int OP_SIZE  = 3,
    localparam int CNT_W    = $clog2(N_STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    ppu_pipe_ctrl_if.slave      bus,
    output logic [N_STAGES-1:0] stage_en_o,
    output logic [N_STAGES-1:0] stage_valid_o,
    output logic                stall_o,
    output logic [CNT_W-1:0]    in_flight_o,
    output logic                idle_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [N_STAGES-1:0] v_q;
    logic [N_STAGES-1:0] v_d;
    logic [OP_SIZE-1:0]  tag_q [N_STAGES];
    logic [OP_SIZE-1:0]  tag_d [N_STAGES];
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    state_t              state_q;
    state_t              state_d;
    logic                adv;

    // The only reason to freeze is a valid output-stage op the consumer
    // refuses; with no bubble collapsing every stage moves together.
    assign adv = !(v_q[N_STAGES-1] && !bus.ready_i);

    // Next stage contents. Flush wipes the valid bits (and drops any
    // same-cycle input) but leaves tags alone since they are don't-care
    // whenever their valid bit is low.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < N_STAGES; k++) begin
            tag_d[k] = tag_q[k];
        end
        if (bus.flush_i) begin
            v_d = '0;
        end else if (adv) begin
            v_d[0]   = bus.valid_i;
            tag_d[0] = bus.op;
            for (int k = 1; k < N_STAGES; k++) begin
                v_d[k]   = v_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    // Counting the next valid vector keeps the registered count in step
    // with stage_valid_o every cycle.
    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            cnt_d = cnt_d + CNT_W'(v_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < N_STAGES; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            cnt_q <= cnt_d;
            for (int k = 0; k < N_STAGES; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // Status FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status FSM: next state. IDLE is entered exactly when the next valid
    // vector is empty, so idle_o always agrees with in_flight_o == 0.
    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (v_d != '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!adv) begin
                        state_d = HOLD;
                    end else if (v_d == '0) begin
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (adv) begin
                        state_d = (v_d == '0) ? IDLE : RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status FSM: outputs. Stall and ready follow ready_i combinationally so
    // the front end sees backpressure in the same cycle it arises.
    always_comb begin
        idle_o      = (state_q == IDLE);
        stall_o     = !adv;
        bus.ready_o = adv;
    end

    assign stage_en_o    = {N_STAGES{adv}};
    assign stage_valid_o = v_q;
    assign in_flight_o   = cnt_q;
    assign bus.valid_o   = v_q[N_STAGES-1];
    assign bus.op_o      = v_q[N_STAGES-1] ? tag_q[N_STAGES-1] : '0;

endmodule

// File: tb/tb_ppu_pipe_ctrl.sv
// tb_ppu_pipe_ctrl
// Directed bench for ppu_pipe_ctrl: a 3-stage instance for the main
// scenarios plus 1-stage and 5-stage instances (8-bit tags) for the sweep.
module tb_ppu_pipe_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ppu_pipe_ctrl_if #(.OP_SIZE(3)) if3 ();
    ppu_pipe_ctrl_if #(.OP_SIZE(8)) if1 ();
    ppu_pipe_ctrl_if #(.OP_SIZE(8)) if5 ();

    logic [2:0] stage_en3, stage_valid3;
    logic       stall3, idle3;
    logic [1:0] in_flight3;

    logic [0:0] stage_en1, stage_valid1;
    logic       stall1, idle1;
    logic [0:0] in_flight1;

    logic [4:0] stage_en5, stage_valid5;
    logic       stall5, idle5;
    logic [2:0] in_flight5;

    ppu_pipe_ctrl #(.N_STAGES(3), .OP_SIZE(3)) dut3 (
        .clk(clk), .rst(rst), .bus(if3),
        .stage_en_o(stage_en3), .stage_valid_o(stage_valid3),
        .stall_o(stall3), .in_flight_o(in_flight3), .idle_o(idle3)
    );

    ppu_pipe_ctrl #(.N_STAGES(1), .OP_SIZE(8)) dut1 (
        .clk(clk), .rst(rst), .bus(if1),
        .stage_en_o(stage_en1), .stage_valid_o(stage_valid1),
        .stall_o(stall1), .in_flight_o(in_flight1), .idle_o(idle1)
    );

    ppu_pipe_ctrl #(.N_STAGES(5), .OP_SIZE(8)) dut5 (
        .clk(clk), .rst(rst), .bus(if5),
        .stage_en_o(stage_en5), .stage_valid_o(stage_valid5),
        .stall_o(stall5), .in_flight_o(in_flight5), .idle_o(idle5)
    );

    // Advance one edge and let outputs settle before anyone looks at them.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ops j in [0, nops) accepted at edge j occupy an n-stage pipe for
    // edges j .. j+n-1.
    function automatic int exp_in_flight(int c, int n, int nops);
        int cnt = 0;
        for (int j = 0; j < nops; j++) begin
            if (j <= c && j > c - n) cnt++;
        end
        return cnt;
    endfunction

    task automatic test_reset();
        rst         = 1'b1;
        if3.valid_i = 1'b0; if3.op = '0; if3.flush_i = 1'b0; if3.ready_i = 1'b1;
        if1.valid_i = 1'b0; if1.op = '0; if1.flush_i = 1'b0; if1.ready_i = 1'b1;
        if5.valid_i = 1'b0; if5.op = '0; if5.flush_i = 1'b0; if5.ready_i = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (if3.valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_valid_o: got %b expected 0", if3.valid_o);
        end
        checks++;
        if (if3.op_o !== 3'd0) begin
            failures++; $display("[TB] FAIL reset_op_o: got %0d expected 0", if3.op_o);
        end
        checks++;
        if (stall3 !== 1'b0 || if3.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_stall_ready: got stall=%b ready=%b expected 0/1", stall3, if3.ready_o);
        end
        checks++;
        if (in_flight3 !== 2'd0 || idle3 !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_count_idle: got cnt=%0d idle=%b expected 0/1", in_flight3, idle3);
        end
        checks++;
        if (stage_valid3 !== 3'b000 || stage_en3 !== 3'b111) begin
            failures++; $display("[TB] FAIL reset_stage: got sv=%b en=%b expected 000/111", stage_valid3, stage_en3);
        end
        checks++;
        if (idle1 !== 1'b1 || idle5 !== 1'b1 || if1.valid_o !== 1'b0 || if5.valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_sweep_duts: got idle1=%b idle5=%b v1=%b v5=%b expected 1/1/0/0",
                                 idle1, idle5, if1.valid_o, if5.valid_o);
        end
    endtask

    task automatic test_single_op();
        logic [2:0] exp_sv;
        logic       exp_v;
        int         exp_cnt;
        if3.valid_i = 1'b1; if3.op = 3'd5;
        step();
        if3.valid_i = 1'b0; if3.op = 3'd0;
        for (int i = 0; i < 4; i++) begin
            exp_v   = (i == 2);
            exp_sv  = (i < 3) ? 3'(1 << i) : 3'b000;
            exp_cnt = (i < 3) ? 1 : 0;
            checks++;
            if (stage_valid3 !== exp_sv) begin
                failures++; $display("[TB] FAIL single_stage_valid[%0d]: got %b expected %b", i, stage_valid3, exp_sv);
            end
            checks++;
            if (if3.valid_o !== exp_v || if3.op_o !== (exp_v ? 3'd5 : 3'd0)) begin
                failures++; $display("[TB] FAIL single_output[%0d]: got v=%b op=%0d expected v=%b op=%0d",
                                     i, if3.valid_o, if3.op_o, exp_v, exp_v ? 5 : 0);
            end
            checks++;
            if (in_flight3 !== 2'(exp_cnt) || idle3 !== (exp_cnt == 0)) begin
                failures++; $display("[TB] FAIL single_count[%0d]: got cnt=%0d idle=%b expected %0d", i, in_flight3, idle3, exp_cnt);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_back_to_back();
        int   peak = 0;
        logic exp_v;
        int   exp_cnt;
        for (int c = 0; c < 8; c++) begin
            if3.valid_i = (c < 6);
            if3.op      = 3'(c);
            step();
            exp_v   = (c >= 2);
            exp_cnt = exp_in_flight(c, 3, 6);
            checks++;
            if (if3.valid_o !== exp_v || if3.op_o !== (exp_v ? 3'(c - 2) : 3'd0)) begin
                failures++; $display("[TB] FAIL b2b_output[%0d]: got v=%b op=%0d expected v=%b op=%0d",
                                     c, if3.valid_o, if3.op_o, exp_v, exp_v ? c - 2 : 0);
            end
            checks++;
            if (in_flight3 !== 2'(exp_cnt) || stall3 !== 1'b0) begin
                failures++; $display("[TB] FAIL b2b_count_stall[%0d]: got cnt=%0d stall=%b expected %0d/0",
                                     c, in_flight3, stall3, exp_cnt);
            end
            if (int'(in_flight3) > peak) peak = int'(in_flight3);
        end
        if3.valid_i = 1'b0; if3.op = 3'd0;
        checks++;
        if (peak !== 3) begin
            failures++; $display("[TB] FAIL b2b_peak: got %0d expected 3", peak);
        end
        step();
        checks++;
        if (idle3 !== 1'b1 || if3.valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_drain: got idle=%b v=%b expected 1/0", idle3, if3.valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic exp_v;
        if3.ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if3.valid_i = 1'b1; if3.op = 3'(i);
            step();
        end
        // Op 4 waits upstream for the whole stall and must enter exactly once.
        if3.valid_i = 1'b1; if3.op = 3'd4;
        if3.ready_i = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stall3 !== 1'b1 || if3.ready_o !== 1'b0 || stage_en3 !== 3'b000) begin
                failures++; $display("[TB] FAIL bp_stall[%0d]: got stall=%b ready=%b en=%b expected 1/0/000",
                                     i, stall3, if3.ready_o, stage_en3);
            end
            checks++;
            if (if3.valid_o !== 1'b1 || if3.op_o !== 3'd1 || stage_valid3 !== 3'b111) begin
                failures++; $display("[TB] FAIL bp_hold[%0d]: got v=%b op=%0d sv=%b expected 1/1/111",
                                     i, if3.valid_o, if3.op_o, stage_valid3);
            end
            step();
        end
        if3.ready_i = 1'b1;
        #1;
        checks++;
        if (stall3 !== 1'b0 || if3.ready_o !== 1'b1 || if3.op_o !== 3'd1) begin
            failures++; $display("[TB] FAIL bp_release: got stall=%b ready=%b op=%0d expected 0/1/1",
                                 stall3, if3.ready_o, if3.op_o);
        end
        step();
        if3.valid_i = 1'b0; if3.op = 3'd0;
        for (int k = 0; k < 4; k++) begin
            exp_v = (k < 3);
            checks++;
            if (if3.valid_o !== exp_v || if3.op_o !== (exp_v ? 3'(k + 2) : 3'd0)) begin
                failures++; $display("[TB] FAIL bp_order[%0d]: got v=%b op=%0d expected v=%b op=%0d",
                                     k, if3.valid_o, if3.op_o, exp_v, exp_v ? k + 2 : 0);
            end
            if (k < 3) step();
        end
        checks++;
        if (idle3 !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_idle: got %b expected 1", idle3);
        end
    endtask

    task automatic test_flush();
        if3.valid_i = 1'b1; if3.op = 3'd6;
        step();
        if3.op = 3'd7;
        step();
        checks++;
        if (stage_valid3 !== 3'b011 || in_flight3 !== 2'd2) begin
            failures++; $display("[TB] FAIL flush_pre: got sv=%b cnt=%0d expected 011/2", stage_valid3, in_flight3);
        end
        if3.flush_i = 1'b1; if3.valid_i = 1'b1; if3.op = 3'd2;
        #1;
        checks++;
        if (if3.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_ready: got %b expected 1", if3.ready_o);
        end
        step();
        if3.flush_i = 1'b0; if3.valid_i = 1'b0; if3.op = 3'd0;
        checks++;
        if (stage_valid3 !== 3'b000 || in_flight3 !== 2'd0 || idle3 !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_clear: got sv=%b cnt=%0d idle=%b expected 000/0/1",
                                 stage_valid3, in_flight3, idle3);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (if3.valid_o !== 1'b0) begin
                failures++; $display("[TB] FAIL flush_no_output[%0d]: got %b expected 0", i, if3.valid_o);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_stall();
        logic exp_v;
        if3.ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if3.valid_i = 1'b1; if3.op = 3'(i);
            step();
        end
        if3.valid_i = 1'b0; if3.op = 3'd0;
        if3.ready_i = 1'b0;
        #1;
        checks++;
        if (stall3 !== 1'b1) begin
            failures++; $display("[TB] FAIL rms_stalled: got %b expected 1", stall3);
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (stage_valid3 !== 3'b000 || if3.valid_o !== 1'b0 || if3.op_o !== 3'd0) begin
            failures++; $display("[TB] FAIL rms_state: got sv=%b v=%b op=%0d expected 000/0/0",
                                 stage_valid3, if3.valid_o, if3.op_o);
        end
        checks++;
        if (in_flight3 !== 2'd0 || idle3 !== 1'b1 || stall3 !== 1'b0 || if3.ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL rms_status: got cnt=%0d idle=%b stall=%b ready=%b expected 0/1/0/1",
                                 in_flight3, idle3, stall3, if3.ready_o);
        end
        if3.ready_i = 1'b1;
        if3.valid_i = 1'b1; if3.op = 3'd5;
        step();
        if3.valid_i = 1'b0; if3.op = 3'd0;
        for (int i = 0; i < 3; i++) begin
            exp_v = (i == 2);
            checks++;
            if (if3.valid_o !== exp_v || if3.op_o !== (exp_v ? 3'd5 : 3'd0)) begin
                failures++; $display("[TB] FAIL rms_latency[%0d]: got v=%b op=%0d expected v=%b op=%0d",
                                     i, if3.valid_o, if3.op_o, exp_v, exp_v ? 5 : 0);
            end
            step();
        end
    endtask

    task automatic test_sweep();
        logic exp_v1, exp_v5;
        int   exp_c1, exp_c5;
        for (int c = 0; c < 11; c++) begin
            if1.valid_i = (c < 6); if1.op = 8'(8'h10 + c);
            if5.valid_i = (c < 6); if5.op = 8'(8'h10 + c);
            step();
            exp_v1 = (c < 6);
            exp_v5 = (c >= 4 && c <= 9);
            exp_c1 = exp_in_flight(c, 1, 6);
            exp_c5 = exp_in_flight(c, 5, 6);
            checks++;
            if (if1.valid_o !== exp_v1 || if1.op_o !== (exp_v1 ? 8'(8'h10 + c) : 8'h00)) begin
                failures++; $display("[TB] FAIL sweep1_output[%0d]: got v=%b op=%0h expected v=%b", c, if1.valid_o, if1.op_o, exp_v1);
            end
            checks++;
            if (in_flight1 !== 1'(exp_c1) || if1.ready_o !== 1'b1 || stall1 !== 1'b0) begin
                failures++; $display("[TB] FAIL sweep1_status[%0d]: got cnt=%0d ready=%b stall=%b expected %0d/1/0",
                                     c, in_flight1, if1.ready_o, stall1, exp_c1);
            end
            checks++;
            if (if5.valid_o !== exp_v5 || if5.op_o !== (exp_v5 ? 8'(8'h10 + c - 4) : 8'h00)) begin
                failures++; $display("[TB] FAIL sweep5_output[%0d]: got v=%b op=%0h expected v=%b", c, if5.valid_o, if5.op_o, exp_v5);
            end
            checks++;
            if (in_flight5 !== 3'(exp_c5) || idle5 !== (exp_c5 == 0) || stall5 !== 1'b0) begin
                failures++; $display("[TB] FAIL sweep5_status[%0d]: got cnt=%0d idle=%b stall=%b expected %0d",
                                     c, in_flight5, idle5, stall5, exp_c5);
            end
        end
        if1.valid_i = 1'b0; if5.valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ppu_pipe_ctrl.md
Name: ppu_pipe_ctrl

Overview:
- Parametrised pipeline control unit for the PPU datapath. Generalises the fixed 3-deep valid-delay controller to N_STAGES stages.
- Adds downstream backpressure (ready/valid on both sides), a per-stage opcode tag shift, flush, and an in-flight counter.
- Sits between the PPU front end (operand/op issue) and the pipelined PPU core. Drives the stage-enable and stage-valid signals that gate every datapath pipeline register.

Parameters:
- N_STAGES, 3: number of pipeline stages (>=1); latency from accepted input to valid_o in cycles.
- OP_SIZE, 3: width of the opcode tag carried alongside each stage valid bit.
- CNT_W, $clog2(N_STAGES+1): width of the in-flight counter (derived; do not override).

Ports:
- clk, input, 1: clock, all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid_i, input, 1: upstream presents an operation this cycle.
- op, input, OP_SIZE: opcode of the presented operation.
- ready_o, input side, output, 1: controller can accept valid_i/op this cycle.
- flush_i, input, 1: discard every in-flight operation.
- ready_i, input, 1: downstream accepts the output-stage operation this cycle.
- valid_o, output, 1: output stage (stage N_STAGES-1) holds a valid operation.
- op_o, output, OP_SIZE: opcode tag of the output-stage operation.
- stage_en_o, output, N_STAGES: per-stage register enable for the datapath.
- stage_valid_o, output, N_STAGES: per-stage valid bits; bit 0 is the input stage.
- stall_o, output, 1: pipeline frozen due to backpressure.
- in_flight_o, output, CNT_W: number of set bits in stage_valid_o.
- idle_o, output, 1: no operation in flight.

Behaviour:
- Reset (rst=1 at clock edge):
  - All stage valid bits, op tags and counter go to 0.
  - Outputs settle to valid_o=0, op_o=0, stall_o=0, ready_o=1, in_flight_o=0, idle_o=1, stage_valid_o=0.
  - Reset takes priority over everything, including mid-stall and mid-flush.
- Advance condition: adv = !(v[N_STAGES-1] && !ready_i). The pipeline is a global-stall shift register, with no bubble collapsing.
  - stall_o = !adv.
  - ready_o = adv.
  - stage_en_o = {N_STAGES{adv}}.
- On adv (and no flush):
  - v[0] <= valid_i.
  - tag[0] <= op.
  - v[k] <= v[k-1] and tag[k] <= tag[k-1] for k>=1.
  - Tags shift even when their valid bit is 0. Tag content is don't-care while its valid bit is low, but op_o is forced to 0 when valid_o=0.
- On !adv: all v/tag hold. valid_i is not accepted, and upstream must hold valid_i/op stable until ready_o=1.
- Transfer definitions:
  - Upstream transfer: valid_i && ready_o.
  - Downstream transfer: valid_o && ready_i.
- flush_i=1 (and rst=0):
  - All v[] cleared next cycle.
  - Same-cycle valid_i is dropped: ready_o is still driven per adv, but the operation is discarded.
  - Tags are not cleared.
  - flush during stall also releases the stall next cycle.
- Derived outputs:
  - valid_o = v[N_STAGES-1].
  - op_o = valid_o ? tag[N_STAGES-1] : 0.
  - stage_valid_o = v.
  - These outputs are registered-state-derived. ready_o and stall_o are combinational on ready_i.
- Latency: an operation accepted at edge t appears on valid_o after edge t+N_STAGES-1, i.e. N_STAGES cycles of occupancy, given no stall. Each stall cycle adds exactly 1 cycle.
- in_flight_o: registered popcount of next v, i.e. it equals popcount(stage_valid_o) in every cycle. Range 0..N_STAGES, never wraps. idle_o = (in_flight_o==0).
- Status FSM (observable only via idle_o/stall_o):
  - States: IDLE (no valid bits set), RUN (some valid, adv=1), HOLD (!adv).
  - IDLE->RUN when a valid_i is accepted.
  - RUN->HOLD when the output stage is valid and ready_i=0.
  - HOLD->RUN when ready_i=1.
  - RUN->IDLE when the last operation drains.
  - Any state ->IDLE on flush or rst.
- Full pipeline (all N_STAGES valid) with ready_i held at 1 sustains 1 op/cycle throughput.
- N_STAGES=1: v[0] is also the output stage; ready_o = !valid_o || ready_i.

Test Plan:
- Reset then single op (N_STAGES=3): valid_i=1 op=5 for one cycle, ready_i=1 -> valid_o=1 op_o=5 exactly 3 cycles after acceptance, for 1 cycle; in_flight_o 1,1,1 then 0; idle_o returns to 1.
- Back-to-back stream: 6 ops with op=0..5 on consecutive cycles, ready_i=1 -> op_o=0..5 on 6 consecutive cycles, in_flight_o peaks at 3, stall_o never asserted.
- Backpressure: pipeline full with ops 1,2,3, ready_i=0 for 4 cycles -> stall_o=1 and ready_o=0 for those cycles, valid_o=1 with op_o=1 held; on ready_i=1, op_o 1,2,3 in order with none lost or duplicated.
- Flush mid-flight: 2 ops in flight plus flush_i=1 with valid_i=1 -> next cycle stage_valid_o=0, in_flight_o=0, idle_o=1; no op emerges on valid_o for N_STAGES cycles.
- Reset mid-stall: full and stalled pipeline, rst=1 for one cycle -> all outputs at reset values on the next cycle; a new op afterwards has normal 3-cycle latency.
- Parameter sweep: N_STAGES=1 and N_STAGES=5, OP_SIZE=8, run the stream test -> latency equals N_STAGES, and ordering and counts match.
